counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
- Sequencer for the team's free-running up-counter datapath: it loads, starts, pauses, stops and terminates a count run against a programmed limit.
- A host issues runs through a valid/ready start handshake and receives a one-cycle done pulse per completed period.
- Sits between host/control logic and the count datapath; replaces ad-hoc reset pulsing as the way to restart the counter.

Parameters:
- WIDTH, 4, count and limit width in bits.
- PRESCALE, 1, clk cycles per count tick (>=1); divider width clog2(PRESCALE), minimum 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- start_valid  input  1  host requests a run.
- start_ready  output  1  high only in IDLE.
- start_limit  input  WIDTH  terminal count, sampled at handshake.
- start_mode  input  1  0 = one-shot, 1 = periodic; sampled at handshake.
- pause  input  1  level; freezes counting while high.
- stop  input  1  abort current run.
- q  output  WIDTH  current count.
- busy  output  1  high in ARM, RUN, HOLD.
- done  output  1  one-cycle pulse per completed period.

Behaviour:
- Reset (rst==0 at an edge): state IDLE, q=0, done=0, busy=0, start_ready=1 after reset, prescaler=0, latched limit/mode=0.
- States: IDLE, ARM, RUN, HOLD, DONE.
- IDLE: start_valid&&start_ready latches limit/mode -> ARM. pause/stop ignored. q holds last value.
- ARM (1 cycle): q<=0, prescaler<=0 -> RUN (or HOLD if pause==1).
- RUN: prescaler counts 0..PRESCALE-1; tick when prescaler==PRESCALE-1 (every cycle if PRESCALE=1).
  - On tick with q!=limit: q<=q+1.
  - On tick with q==limit (terminal): done=1 next cycle. One-shot: -> DONE, q holds limit. Periodic: q<=0, stay RUN.
  - Period = (limit+1)*PRESCALE cycles; limit=0 gives a done every PRESCALE cycles, q stays 0.
- HOLD: entered from RUN/ARM when pause==1. q and prescaler frozen; pause==0 -> RUN, resuming the same prescaler phase.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- stop==1 in ARM/RUN/HOLD -> IDLE next edge, q<=0, no done pulse. Priority: stop > terminal > pause. Simultaneous stop+terminal gives no done.
- q never exceeds limit. No wrap past 2^WIDTH-1: limit=all-ones terminates at all-ones.
- start_valid while busy: not accepted (start_ready=0); the host holds valid. No queuing.
- Reset mid-run: immediate return to reset values at that edge; no done.

Optional Feature:
- Macro COUNTER_SEQ_CTRL_STATUS_EN.
- Defined: adds output period_cnt [7:0], cleared at reset and at each accepted start, incremented per done pulse, saturating at 255. Adds output overrun, 1-cycle pulse when start_valid is high during DONE.
- Undefined: neither port nor logic exists. Core behaviour is identical.

Decomposition:
- Package counter_seq_pkg: state enum (IDLE, ARM, RUN, HOLD, DONE), mode constants MODE_ONESHOT=0 and MODE_PERIODIC=1.
- Sub-module count_core: WIDTH-bit register with clear, enable and hold. It has no compare logic. The FSM, prescaler and terminal compare live in counter_seq_ctrl.

Test Plan (WIDTH=4, PRESCALE=1 unless noted):
- Reset: hold rst=0 for 2 cycles with start_valid=1 -> q=0, done=0, busy=0. After release, start_ready=1.
- One-shot limit=3: handshake at edge N -> ARM at N+1, q=1,2,3 at N+2..N+4. done=1 during cycle after N+5 edge, q=3. IDLE after that with start_ready=1.
- Periodic limit=2, PRESCALE=2: q sequence 0,0,1,1,2,2,0,0... done every 6 cycles. Pause held 4 cycles mid-run -> q frozen, period extended by exactly 4.
- Stop coincident with terminal (periodic, limit=1): no done pulse, q=0, IDLE next cycle. Also rst=0 mid-run -> all outputs at reset values next edge.
- Boundaries: limit=15 one-shot reaches q=15 then done with no wrap. limit=0 periodic gives done every cycle in RUN. start_valid while busy is not accepted until IDLE.
- With COUNTER_SEQ_CTRL_STATUS_EN: 300 periodic periods -> period_cnt saturates at 255. start_valid during DONE -> overrun pulse 1 cycle.

Source files
------------

// File: rtl/counter_seq_ctrl_pkg.sv
// counter_seq_pkg: shared FSM states, run-mode constants and prescaler sizing for counter_seq_ctrl
package counter_seq_pkg;

    typedef enum logic [2:0] {IDLE, ARM, RUN, HOLD, DONE} state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    function automatic int presc_width(input int p);
        return p > 1 ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if: host-side start handshake, run controls and count status; status extras under COUNTER_SEQ_CTRL_STATUS_EN
interface counter_seq_ctrl_if #(parameter int WIDTH = 4);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] start_limit;
    logic             start_mode;
    logic             pause;
    logic             stop;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
`ifdef COUNTER_SEQ_CTRL_STATUS_EN
    logic [7:0]       period_cnt;
    logic             overrun;
    modport master(output start_valid, start_limit, start_mode, pause, stop,
                   input start_ready, q, busy, done, period_cnt, overrun);
    modport slave(input start_valid, start_limit, start_mode, pause, stop,
                  output start_ready, q, busy, done, period_cnt, overrun);
`else
    modport master(output start_valid, start_limit, start_mode, pause, stop,
                   input start_ready, q, busy, done);
    modport slave(input start_valid, start_limit, start_mode, pause, stop,
                  output start_ready, q, busy, done);
`endif
endinterface

// File: rtl/counter_seq_ctrl_count_core.sv
// count_core: WIDTH-bit count register with synchronous clear, increment enable and hold
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             hold,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst || clr) q <= '0;
        else if (en && !hold) q <= q + WIDTH'(1);
    end
endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: load/start/pause/stop/terminate sequencer for the up-counter datapath
// Optional period_cnt/overrun status outputs under COUNTER_SEQ_CTRL_STATUS_EN.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input logic               clk,
    input logic               rst,
    counter_seq_ctrl_if.slave bus
);
    localparam int PW = presc_width(PRESCALE);

    state_t           state, state_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic [WIDTH-1:0] limit;
    logic             mode;
    logic             done_r, done_nxt;
    logic             accept, tick, terminal, q_clr, q_en;

    assign accept   = state == IDLE && bus.start_valid;
    assign tick     = presc == PW'(PRESCALE - 1);
    assign terminal = state == RUN && tick && bus.q == limit;

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        q_clr     = 1'b0;
        q_en      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: state_nxt = accept ? ARM : IDLE;
            ARM: begin
                q_clr     = 1'b1;
                presc_nxt = '0;
                state_nxt = bus.stop ? IDLE : bus.pause ? HOLD : RUN;
            end
            RUN: begin
                if (bus.stop) begin
                    q_clr     = 1'b1;
                    presc_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    presc_nxt = tick ? '0 : presc + PW'(1);
                    done_nxt  = terminal;
                    // terminal outranks pause: the period completes, then the run parks in HOLD
                    q_clr     = terminal && mode == MODE_PERIODIC;
                    q_en      = tick && !terminal;
                    state_nxt = terminal && mode == MODE_ONESHOT ? DONE : bus.pause ? HOLD : RUN;
                end
            end
            HOLD: begin
                q_clr     = bus.stop;
                presc_nxt = bus.stop ? '0 : presc;
                state_nxt = bus.stop ? IDLE : bus.pause ? HOLD : RUN;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            presc  <= '0;
            limit  <= '0;
            mode   <= MODE_ONESHOT;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            presc  <= presc_nxt;
            done_r <= done_nxt;
            if (accept) begin
                limit <= bus.start_limit;
                mode  <= bus.start_mode;
            end
        end
    end

    count_core #(.WIDTH(WIDTH)) core (
        .clk (clk),
        .rst (rst),
        .clr (q_clr),
        .en  (q_en),
        .hold(state == HOLD),
        .q   (bus.q)
    );

    assign bus.start_ready = state == IDLE;
    assign bus.busy        = state == ARM || state == RUN || state == HOLD;
    assign bus.done        = done_r;

`ifdef COUNTER_SEQ_CTRL_STATUS_EN
    logic [7:0] period_cnt;

    always_ff @(posedge clk) begin
        if (!rst || accept) period_cnt <= '0;
        else if (done_nxt && period_cnt != 8'hff) period_cnt <= period_cnt + 8'd1;
    end

    assign bus.period_cnt = period_cnt;
    assign bus.overrun    = state == DONE && bus.start_valid;
`endif
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed checks of counter_seq_ctrl at PRESCALE=1 (d1) and PRESCALE=2 (d2)
module tb_counter_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl_if #(.WIDTH(4)) b1();
    counter_seq_ctrl_if #(.WIDTH(4)) b2();

    counter_seq_ctrl #(.WIDTH(4), .PRESCALE(1)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));
    counter_seq_ctrl #(.WIDTH(4), .PRESCALE(2)) d2 (.clk(clk), .rst(rst), .bus(b2.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start1(input logic [3:0] lim, input logic m);
        b1.start_valid = 1'b1;
        b1.start_limit = lim;
        b1.start_mode  = m;
        step();
        b1.start_valid = 1'b0;
    endtask

    int q_exp_a[13]    = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0};
    int done_exp_a[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    int q_exp_b[9]     = '{1, 1, 1, 1, 1, 1, 2, 2, 0};
    int done_exp_b[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        b1.start_valid = 1'b1; b1.start_limit = '0; b1.start_mode = 1'b0; b1.pause = 1'b0; b1.stop = 1'b0;
        b2.start_valid = 1'b0; b2.start_limit = '0; b2.start_mode = 1'b0; b2.pause = 1'b0; b2.stop = 1'b0;
        step();
        step();
        check("rst_q", b1.q, 0);
        check("rst_done", b1.done, 0);
        check("rst_busy", b1.busy, 0);
        rst = 1'b1;
        b1.start_valid = 1'b0;
        step();
        check("rst_ready", b1.start_ready, 1);
        check("rst_idle_busy", b1.busy, 0);

        // one-shot, limit 3
        start1(4'd3, 1'b0);
        check("os_arm_busy", b1.busy, 1);
        check("os_arm_ready", b1.start_ready, 0);
        step();
        check("os_run_q0", b1.q, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("os_q", b1.q, i);
            check("os_nodone", b1.done, 0);
        end
        step();
        check("os_done", b1.done, 1);
        check("os_done_q", b1.q, 3);
        check("os_done_busy", b1.busy, 0);
        step();
        check("os_idle_done", b1.done, 0);
        check("os_idle_ready", b1.start_ready, 1);
        check("os_idle_q", b1.q, 3);

        // periodic limit 1, stop coincident with terminal
        start1(4'd1, 1'b1);
        step();
        step();
        check("st_q1", b1.q, 1);
        b1.stop = 1'b1;
        step();
        b1.stop = 1'b0;
        check("st_done", b1.done, 0);
        check("st_q", b1.q, 0);
        check("st_idle", b1.start_ready, 1);
        step();
        check("st_done_late", b1.done, 0);

        // periodic limit 0: done every RUN cycle; busy host request refused
        start1(4'd0, 1'b1);
        step();
        check("l0_first", b1.done, 0);
        b1.start_valid = 1'b1;
        b1.start_limit = 4'd5;
        b1.start_mode  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("l0_done", b1.done, 1);
            check("l0_q", b1.q, 0);
            check("busy_ready", b1.start_ready, 0);
        end
        b1.stop = 1'b1;
        step();
        b1.stop = 1'b0;
        check("busy_idle_ready", b1.start_ready, 1);
        check("busy_idle_busy", b1.busy, 0);
        step();
        b1.start_valid = 1'b0;
        check("held_accept", b1.busy, 1);
        step();
        for (int i = 1; i <= 5; i++) begin
            step();
            check("held_q", b1.q, i);
        end
        step();
        check("held_done", b1.done, 1);
        check("held_done_q", b1.q, 5);
        step();

        // limit 15 one-shot: reaches all-ones without wrapping
        start1(4'd15, 1'b0);
        step();
        for (int i = 1; i <= 15; i++) begin
            step();
            check("l15_q", b1.q, i);
        end
        step();
        check("l15_done", b1.done, 1);
        check("l15_q_hold", b1.q, 15);
        step();
        check("l15_idle_q", b1.q, 15);
        check("l15_idle_done", b1.done, 0);

        // reset mid-run
        start1(4'd7, 1'b1);
        step();
        step();
        step();
        check("mr_q2", b1.q, 2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mr_q", b1.q, 0);
        check("mr_busy", b1.busy, 0);
        check("mr_done", b1.done, 0);
        check("mr_ready", b1.start_ready, 1);

        // PRESCALE=2 periodic limit 2, then a 4-cycle pause
        b2.start_valid = 1'b1;
        b2.start_limit = 4'd2;
        b2.start_mode  = 1'b1;
        step();
        b2.start_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step();
            check("p2_q", b2.q, q_exp_a[i]);
            check("p2_done", b2.done, done_exp_a[i]);
        end
        step();
        b2.pause = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 3) b2.pause = 1'b0;
            check("pz_q", b2.q, q_exp_b[i]);
            check("pz_done", b2.done, done_exp_b[i]);
            check("pz_busy", b2.busy, 1);
        end
        b2.stop = 1'b1;
        step();
        b2.stop = 1'b0;
        check("p2_stop_idle", b2.start_ready, 1);

`ifdef COUNTER_SEQ_CTRL_STATUS_EN
        start1(4'd0, 1'b1);
        check("pc_clear", b1.period_cnt, 0);
        step();
        step();
        check("pc_one", b1.period_cnt, 1);
        for (int i = 0; i < 300; i++) step();
        check("pc_sat", b1.period_cnt, 255);
        b1.stop = 1'b1;
        step();
        b1.stop = 1'b0;
        start1(4'd0, 1'b0);
        step();
        b1.start_valid = 1'b1;
        step();
        check("ov_done", b1.done, 1);
        check("ov_pulse", b1.overrun, 1);
        step();
        b1.start_valid = 1'b0;
        check("ov_clear", b1.overrun, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
